expr_checker: RTL
=================

// Module: expr_checker
// PURPOSE
//   Byte-serial recognizer for arithmetic expressions: multi-digit numbers, binary operators, nested parentheses.
//   Parametrised successor to the single-digit "d(op d)*" string checker.
//   Sits behind the byte input stream; flags a complete valid expression, a sticky error and the error position.
//   Grammar: expr := term (op term)* ; term := number | '(' expr ')' ; number := '0'..'9' {1..MAX_DIGITS}.
// PARAMETERS
//   MAX_DEPTH  7  maximum parenthesis nesting (1..2**DEPTH_W-1)
//   DEPTH_W    3  width of depth counter
//   MAX_DIGITS 4  maximum digits per number (>=1); leading zeros allowed
//   POS_W      8  width of byte-position counters
//   ALLOW_SUB  1  1: '-' is a legal operator
//   ALLOW_DIV  0  1: '/' is a legal operator ('+' and '*' always legal)
// PORTS
//   clk       in   1        clock, all state updates on rising edge
//   clr       in   1        synchronous active-high reset
//   in_valid  in   1        in carries a byte this cycle
//   in        in   8        ASCII input byte
//   out       out  1        bytes consumed so far form a complete valid expression
//   err       out  1        sticky syntax error
//   depth     out  DEPTH_W  current open-parenthesis count
//   pos       out  POS_W    number of bytes consumed since clr
//   err_pos   out  POS_W    0-based index of the offending byte (valid while err=1)
// BEHAVIOUR
//   - clr sampled at posedge: state=S_START, depth=0, digit count=0, pos=0, err_pos=0 -> out=0, err=0.
//   - clr has priority over in_valid; a byte presented in a clr cycle is discarded.
//   - in_valid=0: all state held; outputs unchanged.
//   - States: S_START, S_OPND (expect operand), S_NUM, S_CLOSE, S_ERR. cls(in): DIG, OP, LP '(', RP ')', OTHER.
//   - S_START/S_OPND: DIG -> S_NUM, cnt=1; LP -> depth==MAX_DEPTH ? S_ERR : depth+1, S_OPND; else S_ERR.
//   - S_NUM: DIG -> cnt<MAX_DIGITS ? cnt+1 : S_ERR; OP -> S_OPND; RP -> depth==0 ? S_ERR : depth-1, S_CLOSE; else S_ERR.
//   - S_CLOSE: OP -> S_OPND; RP -> as in S_NUM; DIG, LP, OTHER -> S_ERR.
//   - S_ERR: absorbing until clr; depth and pos frozen; in ignored.
//   - OP = '+' | '*' | ('-' if ALLOW_SUB) | ('/' if ALLOW_DIV); a disabled operator is OTHER.
//   - Entering S_ERR: err_pos <= pos (index of the offending byte); that byte does not increment pos.
//   - pos increments on each consumed byte outside S_ERR; saturates at 2**POS_W-1 without error; parsing continues.
//   - out = (state==S_NUM || state==S_CLOSE) && depth==0; Moore output, decoded from registered state.
//     Rises the cycle after the completing byte is sampled.
//   - err = (state==S_ERR); registered, one cycle after the offending byte.
//   - "()" is illegal (RP in S_OPND). An empty stream is not valid (out=0 in S_START).
// TESTING
//   1. Feed "12+(3*45)" back-to-back -> out=1 after ')', depth=0, pos=9, err=0; out=0 after '+', '(', '*'.
//   2. Feed "12345" (MAX_DIGITS=4) -> err=1 after 5th byte, err_pos=4, out=0; further bytes leave pos=4.
//   3. Feed 8x'(' (MAX_DEPTH=7) -> depth reaches 7, err on 8th '(', err_pos=7.
//   4. Feed "(1" -> out=0, depth=1. Then ")" -> out=1, depth=0. Then ")" -> err, err_pos=3.
//   5. Feed "3", idle in_valid=0 for 5 cycles, feed "*" -> out=1 held through idle, pos=1 held; 0 after '*'.
//   6. Assert clr with in_valid=1, in='7' mid-stream -> next cycle pos=0, depth=0, out=0, err=0.
//      With ALLOW_SUB=0, feed "1-2" -> err_pos=1.

Source files
------------

// File: rtl/expr_checker.sv
// Byte-serial recognizer for arithmetic expressions with multi-digit numbers,
// binary operators and nested parentheses; reports validity, sticky error and error position.
module expr_checker #(
    parameter int MAX_DEPTH  = 7,
    parameter int DEPTH_W    = 3,
    parameter int MAX_DIGITS = 4,
    parameter int POS_W      = 8,
    parameter bit ALLOW_SUB  = 1'b1,
    parameter bit ALLOW_DIV  = 1'b0
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               out,
    output logic               err,
    output logic [DEPTH_W-1:0] depth,
    output logic [POS_W-1:0]   pos,
    output logic [POS_W-1:0]   err_pos
);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {S_START, S_OPND, S_NUM, S_CLOSE, S_ERR} state_t;
    typedef enum logic [2:0] {C_DIG, C_OP, C_LP, C_RP, C_OTHER} cls_t;

    state_t             state, state_n;
    cls_t               cls;
    logic [DEPTH_W-1:0] depth_n;
    logic [CNT_W-1:0]   cnt, cnt_n;

    // A disabled operator falls through to C_OTHER and is rejected like any stray byte.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cls = C_OTHER;
        if (in >= 8'h30 && in <= 8'h39)        cls = C_DIG;
        else if (in == 8'h2B || in == 8'h2A)   cls = C_OP;
        else if (in == 8'h2D && ALLOW_SUB)     cls = C_OP;
        else if (in == 8'h2F && ALLOW_DIV)     cls = C_OP;
        else if (in == 8'h28)                  cls = C_LP;
        else if (in == 8'h29)                  cls = C_RP;
    end

    always_comb begin
        state_n = state;
        depth_n = depth;
        cnt_n   = cnt;
        case (state)
            S_START, S_OPND: begin
                if (cls == C_DIG) begin
                    state_n = S_NUM;
                    cnt_n   = CNT_W'(1);
                end else if (cls == C_LP) begin
                    if (depth == DEPTH_W'(MAX_DEPTH)) state_n = S_ERR;
                    else begin
                        state_n = S_OPND;
                        depth_n = depth + 1'b1;
                    end
                end else begin
                    state_n = S_ERR;
                end
            end
            S_NUM, S_CLOSE: begin
                if (cls == C_OP) begin
                    state_n = S_OPND;
                end else if (cls == C_RP) begin
                    if (depth == '0) state_n = S_ERR;
                    else begin
                        state_n = S_CLOSE;
                        depth_n = depth - 1'b1;
                    end
                end else if (cls == C_DIG && state == S_NUM && cnt < CNT_W'(MAX_DIGITS)) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    state_n = S_ERR;
                end
            end
            default: state_n = S_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (clr) begin
            state   <= S_START;
            depth   <= '0;
            cnt     <= '0;
            pos     <= '0;
            err_pos <= '0;
        end else if (in_valid && state != S_ERR) begin
            state <= state_n;
            depth <= depth_n;
            cnt   <= cnt_n;
            if (state_n == S_ERR)         err_pos <= pos;
            else if (pos != {POS_W{1'b1}}) pos     <= pos + 1'b1;
        end
    end

    assign out = (state == S_NUM || state == S_CLOSE) && depth == '0;
    assign err = (state == S_ERR);
endmodule
